// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - 2-bit saturating branch direction predictor with mispredict stats
// Optional BTB (valid/tag/target per entry) enabled by defining BP_BTB_EN.
module branch_predictor #(
    parameter int IDX_W = 4,
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lk_pc,
    output logic            lk_taken,
    output logic            lk_hit,
    output logic [XLEN-1:0] lk_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic            upd_pred,
    input  logic [XLEN-1:0] upd_target,
    input  logic            clr_stats,
    output logic            mispredict,
    output logic [31:0]     br_count,
    output logic [31:0]     mp_count
);
    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]       cnt_q [DEPTH];
    logic [1:0]       cnt_d [DEPTH];
    logic             mispredict_q, mispredict_d;
    logic [31:0]      br_count_q, br_count_d;
    logic [31:0]      mp_count_q, mp_count_d;
    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic             upd_mp;

    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_mp  = upd_valid && (upd_taken != upd_pred);

    assign lk_taken   = cnt_q[lk_idx][1];
    assign mispredict = mispredict_q;
    assign br_count   = br_count_q;
    assign mp_count   = mp_count_q;

    always_comb begin
        cnt_d        = cnt_q;
        mispredict_d = upd_mp;
        br_count_d   = br_count_q;
        mp_count_d   = mp_count_q;
        if (upd_valid) begin
            if (upd_taken) begin
                if (cnt_q[upd_idx] != 2'b11) cnt_d[upd_idx] = cnt_q[upd_idx] + 2'd1;
            end else begin
                if (cnt_q[upd_idx] != 2'b00) cnt_d[upd_idx] = cnt_q[upd_idx] - 2'd1;
            end
        end
        // Clear has priority over counting the same-cycle update.
        if (clr_stats) begin
            br_count_d = '0;
            mp_count_d = '0;
        end else begin
            if (upd_valid && br_count_q != 32'hFFFF_FFFF) br_count_d = br_count_q + 32'd1;
            if (upd_mp && mp_count_q != 32'hFFFF_FFFF) mp_count_d = mp_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= 2'b01;
            mispredict_q <= 1'b0;
            br_count_q   <= '0;
            mp_count_q   <= '0;
        end else begin
            cnt_q        <= cnt_d;
            mispredict_q <= mispredict_d;
            br_count_q   <= br_count_d;
            mp_count_q   <= mp_count_d;
        end
    end

`ifdef BP_BTB_EN
    logic             valid_q [DEPTH];
    logic             valid_d [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];
    logic [XLEN-1:0]  tgt_q [DEPTH];
    logic [XLEN-1:0]  tgt_d [DEPTH];
    logic [TAG_W-1:0] lk_tag, upd_tag;

    assign lk_tag  = lk_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_target = lk_hit ? tgt_q[lk_idx] : '0;

    // Only taken branches allocate; not-taken updates leave the entry alone.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        if (upd_valid && upd_taken) begin
            valid_d[upd_idx] = 1'b1;
            tag_d[upd_idx]   = upd_tag;
            tgt_d[upd_idx]   = upd_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{lk_pc[XLEN-1:IDX_W+TAG_W+2], lk_pc[1:0],
                           upd_pc[XLEN-1:IDX_W+TAG_W+2], upd_pc[1:0]};
`else
    assign lk_hit    = 1'b0;
    assign lk_target = '0;

    logic unused_bits;
    assign unused_bits = ^{lk_pc[XLEN-1:IDX_W+2], lk_pc[1:0],
                           upd_pc[XLEN-1:IDX_W+2], upd_pc[1:0], upd_target};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lk_pc;
    logic        lk_taken;
    logic        lk_hit;
    logic [31:0] lk_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_pred;
    logic [31:0] upd_target;
    logic        clr_stats;
    logic        mispredict;
    logic [31:0] br_count;
    logic [31:0] mp_count;

    int tests  = 0;
    int failed = 0;

    branch_predictor #(.IDX_W(4), .XLEN(32), .TAG_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .lk_pc      (lk_pc),
        .lk_taken   (lk_taken),
        .lk_hit     (lk_hit),
        .lk_target  (lk_target),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_pred   (upd_pred),
        .upd_target (upd_target),
        .clr_stats  (clr_stats),
        .mispredict (mispredict),
        .br_count   (br_count),
        .mp_count   (mp_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic v, input logic [31:0] pc, input logic t, input logic p);
        upd_valid = v;
        upd_pc    = pc;
        upd_taken = t;
        upd_pred  = p;
    endtask

    initial begin
        rst = 1'b1; lk_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_pred = 1'b0; upd_target = '0; clr_stats = 1'b0;
        #2;
        chk("async_reset_mp", 32'(mispredict), 32'd0);
        chk("async_reset_br", br_count, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) begin
            lk_pc = 32'(i * 4);
            #1 chk($sformatf("reset_taken_%0d", i), 32'(lk_taken), 32'd0);
        end
        chk("reset_mispredict", 32'(mispredict), 32'd0);
        chk("reset_br", br_count, 32'd0);
        chk("reset_mp", mp_count, 32'd0);
        chk("reset_hit", 32'(lk_hit), 32'd0);
        chk("reset_target", lk_target, 32'd0);

        lk_pc = 32'h40;
        upd(1'b1, 32'h40, 1'b1, 1'b0);
        tick();
        chk("t2_taken_e1", 32'(lk_taken), 32'd1);
        chk("t2_mp_e1", 32'(mispredict), 32'd1);
        chk("t2_br_e1", br_count, 32'd1);
        tick();
        chk("t2_mp_e2", 32'(mispredict), 32'd1);
        chk("t2_br_e2", br_count, 32'd2);
        chk("t2_mpc_e2", mp_count, 32'd2);
        upd(1'b0, 32'h40, 1'b0, 1'b1);
        tick();
        chk("t2_mp_idle", 32'(mispredict), 32'd0);
        chk("t2_br_idle", br_count, 32'd2);

        upd(1'b1, 32'h80, 1'b0, 1'b1);
        tick();
        chk("t3_st_to_wt", 32'(lk_taken), 32'd1);
        tick();
        chk("t3_wt_to_wnt", 32'(lk_taken), 32'd0);
        upd(1'b1, 32'h80, 1'b0, 1'b0);
        tick();
        chk("t3_alias_taken", 32'(lk_taken), 32'd0);
        chk("t3_mp_correct", 32'(mispredict), 32'd0);
        chk("t3_br", br_count, 32'd5);
        chk("t3_mpc", mp_count, 32'd4);
        upd(1'b0, 32'h0, 1'b0, 1'b0);
        tick();

        lk_pc = 32'h44;
        upd(1'b1, 32'h44, 1'b1, 1'b0);
        clr_stats = 1'b1;
        #1 chk("t4_no_bypass", 32'(lk_taken), 32'd0);
        tick();
        chk("t4_after_edge", 32'(lk_taken), 32'd1);
        chk("t4_clr_br", br_count, 32'd0);
        chk("t4_clr_mpc", mp_count, 32'd0);
        chk("t4_mp_pulse", 32'(mispredict), 32'd1);
        clr_stats = 1'b0;
        upd(1'b0, 32'h0, 1'b0, 1'b0);
        tick();

        upd(1'b1, 32'h48, 1'b1, 1'b0);
        tick();
        upd(1'b1, 32'h48, 1'b1, 1'b1);
        tick();
        tick();
        upd(1'b1, 32'h4C, 1'b0, 1'b0);
        tick();
        upd(1'b1, 32'h4C, 1'b0, 1'b1);
        tick();
        lk_pc = 32'h48;
        #1 chk("t5_sat_st", 32'(lk_taken), 32'd1);
        chk("t5_br5", br_count, 32'd5);
        chk("t5_mpc2", mp_count, 32'd2);
        chk("t5_mp_pre", 32'(mispredict), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_mp", 32'(mispredict), 32'd0);
        chk("t5_async_br", br_count, 32'd0);
        chk("t5_async_mpc", mp_count, 32'd0);
        chk("t5_async_taken", 32'(lk_taken), 32'd0);
        tick();
        upd(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            lk_pc = 32'h40 + 32'(i * 4);
            #1 chk($sformatf("t5_post_taken_%0d", i), 32'(lk_taken), 32'd0);
        end

`ifdef BP_BTB_EN
        upd(1'b1, 32'h100, 1'b1, 1'b0);
        upd_target = 32'h200;
        tick();
        upd(1'b0, 32'h0, 1'b0, 1'b0);
        lk_pc = 32'h100;
        #1 chk("t6_hit", 32'(lk_hit), 32'd1);
        chk("t6_target", lk_target, 32'h200);
        lk_pc = 32'h140;
        #1 chk("t6_tag_miss", 32'(lk_hit), 32'd0);
        chk("t6_miss_target", lk_target, 32'd0);
        upd(1'b1, 32'h100, 1'b0, 1'b1);
        upd_target = 32'h300;
        tick();
        upd(1'b0, 32'h0, 1'b0, 1'b0);
        lk_pc = 32'h100;
        #1 chk("t6_nt_keeps_hit", 32'(lk_hit), 32'd1);
        chk("t6_nt_keeps_target", lk_target, 32'h200);
`else
        upd(1'b1, 32'h100, 1'b1, 1'b0);
        upd_target = 32'h200;
        tick();
        upd(1'b0, 32'h0, 1'b0, 1'b0);
        lk_pc = 32'h100;
        #1 chk("t6_nobtb_hit", 32'(lk_hit), 32'd0);
        chk("t6_nobtb_target", lk_target, 32'd0);
        chk("t6_nobtb_dir", 32'(lk_taken), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
